// File: rtl/trace_dump_pkg.sv
// Shared state encoding, beat kinds and halt causes for the trace dump controller.
package trace_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_HDR,
        ST_FETCH,
        ST_PRESENT,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        KIND_PC     = 2'd0,
        KIND_STATUS = 2'd1,
        KIND_REG    = 2'd2,
        KIND_MEM    = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_END_PC     = 2'd1,
        CAUSE_TIMEOUT    = 2'd2,
        CAUSE_INVALID_PC = 2'd3
    } cause_e;

    localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/trace_dump_ctrl_if.sv
// CPU-side and dump-sink signals of the trace dump controller.
interface trace_dump_ctrl_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned DM_DEPTH = 128
);
    logic                        start;
    logic                        dump_mem_en;
    logic [XLEN-1:0]             pc;
    logic                        pc_valid;
    logic                        cpu_halt;
    logic [$clog2(NREG)-1:0]     reg_sel;
    logic [XLEN-1:0]             reg_data;
    logic [$clog2(DM_DEPTH)-1:0] mem_addr;
    logic [XLEN-1:0]             mem_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [1:0]                  out_kind;
    logic [7:0]                  out_index;
    logic [XLEN-1:0]             out_data;
    logic [1:0]                  cause;
    logic                        done;

    modport master (
        input  start, dump_mem_en, pc, pc_valid, reg_data, mem_data, out_ready,
        output cpu_halt, reg_sel, mem_addr, out_valid, out_kind, out_index,
               out_data, cause, done
    );

    modport slave (
        output start, dump_mem_en, pc, pc_valid, reg_data, mem_data, out_ready,
        input  cpu_halt, reg_sel, mem_addr, out_valid, out_kind, out_index,
               out_data, cause, done
    );
endinterface

// File: rtl/trace_dump_ctrl_halt_detect.sv
// Run-phase cycle/stall counting and halt trigger selection.
module halt_detect
    import trace_dump_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] END_PC      = 32'h0000_0310,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned STALL_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             run,
    input  logic [XLEN-1:0]  pc,
    input  logic             pc_valid,
    output logic             trig,
    output cause_e           trig_cause,
    output logic [CNT_W-1:0] cycle_now
);
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d, stall_now;

    // Counter values including the current run cycle, and the prioritised trigger.
    always_comb begin
        cycle_now  = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
        stall_now  = pc_valid ? '0 : ((stall_q == '1) ? stall_q : stall_q + 1'b1);
        cycle_d    = cycle_q;
        stall_d    = stall_q;
        trig       = 1'b0;
        trig_cause = CAUSE_NONE;
        if (clear) begin
            cycle_d = '0;
            stall_d = '0;
        end else if (run) begin
            cycle_d = cycle_now;
            stall_d = stall_now;
        end
        if (run) begin
            if (pc == XLEN'(END_PC)) begin
                trig       = 1'b1;
                trig_cause = CAUSE_END_PC;
            end else if (stall_now >= STALL_LIMIT) begin
                trig       = 1'b1;
                trig_cause = CAUSE_INVALID_PC;
            end else if (cycle_now >= TIMEOUT) begin
                trig       = 1'b1;
                trig_cause = CAUSE_TIMEOUT;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: rtl/trace_dump_ctrl.sv
// Halts the CPU on a trigger and streams PC, status, registers and memory as beats.
module trace_dump_ctrl
    import trace_dump_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NREG        = 32,
    parameter int unsigned DM_DEPTH    = 128,
    parameter logic [31:0] END_PC      = 32'h0000_0310,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned STALL_LIMIT = 3
) (
    input logic               clk,
    input logic               rstn,
    trace_dump_ctrl_if.master bus
);
    localparam int unsigned RSW = $clog2(NREG);
    localparam int unsigned MAW = $clog2(DM_DEPTH);

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    kind_e            kind_q, kind_d;
    logic [7:0]       idx_q, idx_d;
    logic [XLEN-1:0]  data_q, data_d;
    cause_e           cause_q, cause_d;
    logic [CNT_W-1:0] cnt_lat_q, cnt_lat_d;
    logic             mem_en_q, mem_en_d;
    logic [RSW-1:0]   reg_sel_q, reg_sel_d;
    logic [MAW-1:0]   mem_addr_q, mem_addr_d;

    logic             clear;
    logic             trig;
    cause_e           trig_cause;
    logic [CNT_W-1:0] cycle_now;

    halt_detect #(
        .XLEN        (XLEN),
        .END_PC      (END_PC),
        .TIMEOUT     (TIMEOUT),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_halt_detect (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (clear),
        .run        (state_q == ST_RUN),
        .pc         (bus.pc),
        .pc_valid   (bus.pc_valid),
        .trig       (trig),
        .trig_cause (trig_cause),
        .cycle_now  (cycle_now)
    );

    // Next-state and beat register updates; kind_q doubles as the current dump section.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        kind_d     = kind_q;
        idx_d      = idx_q;
        data_d     = data_q;
        cause_d    = cause_q;
        cnt_lat_d  = cnt_lat_q;
        mem_en_d   = mem_en_q;
        reg_sel_d  = reg_sel_q;
        mem_addr_d = mem_addr_q;
        clear      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d  = ST_RUN;
                    clear    = 1'b1;
                    cause_d  = CAUSE_NONE;
                    mem_en_d = bus.dump_mem_en;
                end
            end
            ST_RUN: begin
                if (trig) begin
                    state_d   = ST_HDR;
                    cause_d   = trig_cause;
                    cnt_lat_d = cycle_now;
                    valid_d   = 1'b1;
                    kind_d    = KIND_PC;
                    idx_d     = '0;
                    data_d    = bus.pc;
                end
            end
            ST_HDR: begin
                if (bus.out_ready) begin
                    if (kind_q == KIND_PC) begin
                        kind_d = KIND_STATUS;
                        idx_d  = 8'(cause_q);
                        data_d = XLEN'(cnt_lat_q);
                    end else begin
                        valid_d   = 1'b0;
                        kind_d    = KIND_REG;
                        idx_d     = '0;
                        reg_sel_d = '0;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                valid_d = 1'b1;
                state_d = ST_PRESENT;
                if (kind_q == KIND_REG) begin
                    data_d = (idx_q == 8'd0) ? '0 : bus.reg_data;
                end else begin
                    data_d = bus.mem_data;
                end
            end
            ST_PRESENT: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    if (kind_q == KIND_REG && idx_q != 8'(NREG - 1)) begin
                        idx_d     = idx_q + 8'd1;
                        reg_sel_d = RSW'(idx_q + 8'd1);
                        state_d   = ST_FETCH;
                    end else if (kind_q == KIND_REG && mem_en_q) begin
                        kind_d     = KIND_MEM;
                        idx_d      = '0;
                        mem_addr_d = '0;
                        state_d    = ST_FETCH;
                    end else if (kind_q == KIND_MEM && idx_q != 8'(DM_DEPTH - 1)) begin
                        idx_d      = idx_q + 8'd1;
                        mem_addr_d = MAW'(idx_q + 8'd1);
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            kind_q     <= KIND_PC;
            idx_q      <= '0;
            data_q     <= '0;
            cause_q    <= CAUSE_NONE;
            cnt_lat_q  <= '0;
            mem_en_q   <= 1'b0;
            reg_sel_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            kind_q     <= kind_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            cause_q    <= cause_d;
            cnt_lat_q  <= cnt_lat_d;
            mem_en_q   <= mem_en_d;
            reg_sel_q  <= reg_sel_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.cpu_halt  = (state_q == ST_HDR) || (state_q == ST_FETCH) ||
                           (state_q == ST_PRESENT) || (state_q == ST_DONE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.out_valid = valid_q;
    assign bus.out_kind  = kind_q;
    assign bus.out_index = idx_q;
    assign bus.out_data  = data_q;
    assign bus.cause     = cause_q;
    assign bus.reg_sel   = reg_sel_q;
    assign bus.mem_addr  = mem_addr_q;
endmodule

// File: doc/trace_dump_ctrl.md
TRACE_DUMP_CTRL -- requirements
Module: trace_dump_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/PC width.
REQ-002 SHALL have parameter NREG, default 32, meaning register-file entries dumped.
REQ-003 SHALL have parameter DM_DEPTH, default 128, meaning data-memory words dumped.
REQ-004 SHALL have parameter END_PC, default 32'h0000_0310, meaning program-end address.
REQ-005 SHALL have parameter TIMEOUT, default 1000, meaning maximum run cycles.
REQ-006 SHALL have parameter STALL_LIMIT, default 3, meaning consecutive invalid-PC cycles before halt.
REQ-007 SHALL have ports:
 clk  in  1  clock, rising edge;
 rstn  in  1  reset, synchronous, active-low;
 start  in  1  single-cycle run request;
 dump_mem_en  in  1  include data-memory dump, sampled with start;
 pc  in  XLEN  CPU program counter;
 pc_valid  in  1  PC is a legal fetch address;
 cpu_halt  out  1  freezes CPU state;
 reg_sel  out  $clog2(NREG)  register read select;
 reg_data  in  XLEN  register read data, combinational from reg_sel;
 mem_addr  out  $clog2(DM_DEPTH)  data-memory word address;
 mem_data  in  XLEN  memory read data, combinational from mem_addr;
 out_valid  out  1  dump beat valid;
 out_ready  in  1  sink accepts beat;
 out_kind  out  2  0=PC, 1=STATUS, 2=REG, 3=MEM;
 out_index  out  8  register/word index of beat;
 out_data  out  XLEN  beat payload;
 cause  out  2  0=none, 1=end PC, 2=timeout, 3=invalid PC;
 done  out  1  dump complete.

Function
REQ-008 SHALL implement FSM states IDLE, RUN, HDR, FETCH, PRESENT, DONE.
REQ-009 IDLE: start -> RUN; cycle counter cleared; stall counter cleared; cause cleared; dump_mem_en latched.
REQ-010 RUN: cycle counter increments every cycle, saturating at 2^32-1; stall counter increments while pc_valid=0, clears when pc_valid=1.
REQ-011 RUN halt triggers: pc==END_PC -> cause 1; stall counter reaching STALL_LIMIT -> cause 3; cycle counter reaching TIMEOUT -> cause 2; same-cycle priority 1 > 3 > 2.
REQ-012 On trigger: pc and cycle count latched; cpu_halt asserted from the next cycle until leaving DONE; state -> HDR.
REQ-013 HDR: beat 0 kind=PC, index=0, data=latched pc; beat 1 kind=STATUS, index=cause, data=latched cycle count.
REQ-014 FETCH: drives reg_sel/mem_addr with current index; next cycle captures reg_data/mem_data into out_data register and enters PRESENT; each REG/MEM beat therefore appears one cycle after its select.
REQ-015 PRESENT: out_valid=1; kind, index, data held stable until out_valid&out_ready; on transfer index increments -> FETCH, or section ends.
REQ-016 REG section: indices 0..NREG-1; index 0 reports data 0 regardless of reg_data.
REQ-017 MEM section: indices 0..DM_DEPTH-1 only if latched dump_mem_en=1; otherwise skipped.
REQ-018 After last beat -> DONE: done=1, out_valid=0, cpu_halt=1; start -> RUN with counters cleared and cpu_halt deasserted next cycle.
REQ-019 start SHALL be ignored in RUN, HDR, FETCH, PRESENT.
REQ-020 out_valid SHALL never deassert without a completed handshake except on reset.

Reset
REQ-021 rstn=0 at a rising edge SHALL force IDLE and clear all outputs to 0 (cpu_halt, out_valid, done, cause, reg_sel, mem_addr, out_*), including mid-dump; in-flight beat discarded.

Structure
REQ-022 FSM state encoding, out_kind and cause codes SHALL reside in shared package trace_dump_pkg.
REQ-023 Halt detection (cycle counter, stall counter, trigger priority) SHALL be sub-module halt_detect; sequencing and handshake in the top.

Verification
REQ-024 pc reaches 0x310 at cycle 40, out_ready=1 -> cause=1, beat 0 data 0x310, beat 1 data 40, 32 REG beats, done.
REQ-025 pc never reaches END_PC -> cause=2 after 1000 run cycles, STATUS beat data 1000.
REQ-026 pc_valid=0 for 2 cycles then 1, later 0 for 3 cycles -> no halt on first gap, cause=3 on third cycle of second gap.
REQ-027 pc==END_PC and stall limit in same cycle -> cause=1.
REQ-028 dump_mem_en=1, out_ready toggled randomly -> 2+32+128 beats, indices contiguous, data stable under backpressure, reg index 0 data 0.
REQ-029 rstn=0 during MEM beat 50 -> next cycle all outputs 0, IDLE; subsequent start runs cleanly.
